alu: RTL and testbench



---
 rtl/alu_pkg.sv | 46 ++++
 rtl/alu_shifter.sv | 60 ++++++
 rtl/alu.sv | 145 ++++++++++++++
 tb/tb_alu.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared ALU opcode encodings, width default and flag helpers.
// Imported by the ALU, its shifter and the control-unit decoder.
package alu_pkg;

  localparam int ALU_WIDTH = 32;
  localparam int SH_W      = 5;

  localparam logic [3:0] ALU_ADDU = 4'b0000;
  localparam logic [3:0] ALU_SUBU = 4'b0001;
  localparam logic [3:0] ALU_ADD  = 4'b0010;
  localparam logic [3:0] ALU_SUB  = 4'b0011;
  localparam logic [3:0] ALU_AND  = 4'b0100;
  localparam logic [3:0] ALU_OR   = 4'b0101;
  localparam logic [3:0] ALU_XOR  = 4'b0110;
  localparam logic [3:0] ALU_NOR  = 4'b0111;
  localparam logic [3:0] ALU_LUI  = 4'b1000;
  localparam logic [3:0] ALU_SLTU = 4'b1010;
  localparam logic [3:0] ALU_SLT  = 4'b1011;
  localparam logic [3:0] ALU_SRA  = 4'b1100;
  localparam logic [3:0] ALU_SRL  = 4'b1101;
  localparam logic [3:0] ALU_SLL  = 4'b1110;

  typedef enum logic [1:0] {
    SH_SLL = 2'd0,
    SH_SRL = 2'd1,
    SH_SRA = 2'd2
  } shift_mode_t;

  // Signed overflow from the operand and result sign bits.
  function automatic logic add_ovf(
    input logic sa,
    input logic sb,
    input logic sr
  );
    return (sa == sb) && (sr != sa);
  endfunction

  function automatic logic sub_ovf(
    input logic sa,
    input logic sb,
    input logic sr
  );
    return (sa != sb) && (sr != sa);
  endfunction

endpackage

// File: rtl/alu_shifter.sv
// Five-stage logarithmic barrel shifter with shift-out bit.
// Left shifts reuse the right-shift network on a bit-reversed word.
import alu_pkg::*;

module alu_shifter #(
  parameter int WIDTH = ALU_WIDTH
) (
  input  logic [WIDTH-1:0] b,
  input  logic [SH_W-1:0]  sh,
  input  shift_mode_t      mode,
  output logic [WIDTH-1:0] res,
  output logic             shout
);

  logic [WIDTH-1:0] src;
  logic [WIDTH-1:0] cur;
  logic [WIDTH-1:0] fill_mask;
  logic             fill;
  logic             left;

  assign left = (mode == SH_SLL);
  assign fill = (mode == SH_SRA) & b[WIDTH-1];

  always_comb begin
    src = b;
    if (left) begin
      for (int i = 0; i < WIDTH; i++) begin
        src[i] = b[WIDTH-1-i];
      end
    end
  end

  // Ascending stages: the highest active stage
  // leaves the bit at distance sh-1 as shout.
  always_comb begin
    cur       = src;
    shout     = 1'b0;
    fill_mask = '0;
    for (int k = 0; k < SH_W; k++) begin
      if (sh[k]) begin
        shout     = cur[(1 << k) - 1];
        fill_mask = ~({WIDTH{1'b1}} >> (1 << k));
        cur       = cur >> (1 << k);
        if (fill) begin
          cur = cur | fill_mask;
        end
      end
    end
  end

  always_comb begin
    res = cur;
    if (left) begin
      for (int i = 0; i < WIDTH; i++) begin
        res[i] = cur[WIDTH-1-i];
      end
    end
  end

endmodule

// File: rtl/alu.sv
// Execute-stage integer ALU: 14 ops, one-cycle registered
// result with zero/carry/negative/overflow flags.
import alu_pkg::*;

module alu #(
  parameter int WIDTH = ALU_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       aluc,
  output logic [WIDTH-1:0] r,
  output logic             zero,
  output logic             carry,
  output logic             negative,
  output logic             overflow
);

  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   diff;
  logic             ltu;
  logic             lts;
  logic [WIDTH-1:0] sh_res;
  logic             sh_out;
  shift_mode_t      sh_mode;

  logic op_addu;
  logic op_subu;
  logic op_add;
  logic op_sub;
  logic op_and;
  logic op_or;
  logic op_xor;
  logic op_nor;
  logic op_lui;
  logic op_sltu;
  logic op_slt;
  logic op_sra;
  logic op_srl;
  logic op_sll;

  logic [WIDTH-1:0] nr;
  logic             nc;
  logic             nv;

  assign op_addu = (aluc == ALU_ADDU);
  assign op_subu = (aluc == ALU_SUBU);
  assign op_add  = (aluc == ALU_ADD);
  assign op_sub  = (aluc == ALU_SUB);
  assign op_and  = (aluc == ALU_AND);
  assign op_or   = (aluc == ALU_OR);
  assign op_xor  = (aluc == ALU_XOR);
  assign op_nor  = (aluc == ALU_NOR);
  assign op_lui  = (aluc[3:1] == ALU_LUI[3:1]);
  assign op_sltu = (aluc == ALU_SLTU);
  assign op_slt  = (aluc == ALU_SLT);
  assign op_sra  = (aluc == ALU_SRA);
  assign op_srl  = (aluc == ALU_SRL);
  assign op_sll  = (aluc[3:1] == ALU_SLL[3:1]);

  assign sum  = {1'b0, a} + {1'b0, b};
  assign diff = {1'b0, a} - {1'b0, b};
  assign ltu  = diff[WIDTH];
  assign lts  = $signed(a) < $signed(b);

  always_comb begin
    sh_mode = SH_SLL;
    if (op_sra) begin
      sh_mode = SH_SRA;
    end else if (op_srl) begin
      sh_mode = SH_SRL;
    end
  end

  alu_shifter #(
    .WIDTH (WIDTH)
  ) u_shifter (
    .b     (b),
    .sh    (a[SH_W-1:0]),
    .mode  (sh_mode),
    .res   (sh_res),
    .shout (sh_out)
  );

  always_comb begin
    nr = '0;
    nc = 1'b0;
    nv = 1'b0;
    unique case (1'b1)
      op_addu: begin
        nr = sum[WIDTH-1:0];
        nc = sum[WIDTH];
      end
      op_add: begin
        nr = sum[WIDTH-1:0];
        nv = add_ovf(a[WIDTH-1], b[WIDTH-1],
                     sum[WIDTH-1]);
      end
      op_subu: begin
        nr = diff[WIDTH-1:0];
        nc = ltu;
      end
      op_sub: begin
        nr = diff[WIDTH-1:0];
        nv = sub_ovf(a[WIDTH-1], b[WIDTH-1],
                     diff[WIDTH-1]);
      end
      op_and: nr = a & b;
      op_or:  nr = a | b;
      op_xor: nr = a ^ b;
      op_nor: nr = ~(a | b);
      op_lui: nr = {b[15:0], {(WIDTH-16){1'b0}}};
      op_sltu: begin
        nr = {{(WIDTH-1){1'b0}}, ltu};
        nc = ltu;
      end
      op_slt: nr = {{(WIDTH-1){1'b0}}, lts};
      op_sra, op_srl, op_sll: begin
        nr = sh_res;
        nc = sh_out;
      end
      default: begin
        nr = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r        <= '0;
      zero     <= 1'b0;
      carry    <= 1'b0;
      negative <= 1'b0;
      overflow <= 1'b0;
    end else begin
      r        <= nr;
      zero     <= (nr == '0);
      carry    <= nc;
      negative <= nr[WIDTH-1];
      overflow <= nv;
    end
  end

endmodule

// File: tb/tb_alu.sv
// Self-checking bench for alu: arithmetic reference model checked
// every cycle, plus hand-computed directed vectors.
module tb_alu;

  logic        clk;
  logic        rst_n;
  logic [31:0] a;
  logic [31:0] b;
  logic [3:0]  aluc;
  logic [31:0] r;
  logic        zero;
  logic        carry;
  logic        negative;
  logic        overflow;

  int nchk;
  int nfail;
  bit done;

  typedef struct packed {
    logic [31:0] r;
    logic        z;
    logic        c;
    logic        n;
    logic        v;
  } res_t;

  alu dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .a        (a),
    .b        (b),
    .aluc     (aluc),
    .r        (r),
    .zero     (zero),
    .carry    (carry),
    .negative (negative),
    .overflow (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic res_t model(
    input logic [31:0] ma,
    input logic [31:0] mb,
    input logic [3:0]  op
  );
    res_t   e;
    longint ua;
    longint ub;
    longint sa;
    longint sb;
    longint t;
    int     sh;
    ua = longint'(ma);
    ub = longint'(mb);
    sa = longint'($signed(ma));
    sb = longint'($signed(mb));
    sh = int'(ma[4:0]);
    e  = '0;
    case (op)
      4'd0: begin
        t   = ua + ub;
        e.r = t[31:0];
        e.c = (t > 64'sd4294967295);
      end
      4'd2: begin
        t   = sa + sb;
        e.r = t[31:0];
        e.v = (t > 64'sd2147483647) || (t < -64'sd2147483648);
      end
      4'd1: begin
        t   = ua - ub;
        e.r = t[31:0];
        e.c = (ua < ub);
      end
      4'd3: begin
        t   = sa - sb;
        e.r = t[31:0];
        e.v = (t > 64'sd2147483647) || (t < -64'sd2147483648);
      end
      4'd4: e.r = ma & mb;
      4'd5: e.r = ma | mb;
      4'd6: e.r = ma ^ mb;
      4'd7: e.r = ~(ma | mb);
      4'd8, 4'd9: e.r = mb << 16;
      4'd10: begin
        e.r = (ua < ub) ? 32'd1 : 32'd0;
        e.c = (ua < ub);
      end
      4'd11: e.r = (sa < sb) ? 32'd1 : 32'd0;
      4'd12: begin
        e.r = $signed(mb) >>> sh;
        e.c = (sh == 0) ? 1'b0 : mb[sh-1];
      end
      4'd13: begin
        e.r = mb >> sh;
        e.c = (sh == 0) ? 1'b0 : mb[sh-1];
      end
      default: begin
        e.r = mb << sh;
        e.c = (sh == 0) ? 1'b0 : mb[32-sh];
      end
    endcase
    e.z = (e.r == 32'd0);
    e.n = e.r[31];
    return e;
  endfunction

  task automatic chk(
    input string       nm,
    input logic [31:0] act,
    input logic [31:0] exp
  );
    nchk++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %h expected %h at %0t",
               nm, act, exp, $time);
    end
  endtask

  task automatic cmp(input string tag, input res_t e);
    chk({tag, ".r"}, r, e.r);
    chk({tag, ".zero"}, {31'd0, zero}, {31'd0, e.z});
    chk({tag, ".carry"}, {31'd0, carry}, {31'd0, e.c});
    chk({tag, ".neg"}, {31'd0, negative}, {31'd0, e.n});
    chk({tag, ".ovf"}, {31'd0, overflow}, {31'd0, e.v});
  endtask

  // Every edge: reference result for the inputs seen at the edge.
  res_t ecyc;
  always @(posedge clk) begin
    if (rst_n) ecyc = model(a, b, aluc);
    else       ecyc = '0;
    #1;
    if (!done) cmp("cycle", ecyc);
  end

  // Directed vector: flags given as {zero, carry, negative, overflow}.
  task automatic vec(
    input string       nm,
    input logic [31:0] va,
    input logic [31:0] vb,
    input logic [3:0]  op,
    input logic [31:0] er,
    input logic [3:0]  ef
  );
    res_t e;
    @(negedge clk);
    a    = va;
    b    = vb;
    aluc = op;
    @(posedge clk);
    #2;
    e = '{r: er, z: ef[3], c: ef[2], n: ef[1], v: ef[0]};
    cmp(nm, e);
  endtask

  initial begin
    nchk  = 0;
    nfail = 0;
    done  = 1'b0;
    rst_n = 1'b0;
    a     = $urandom;
    b     = $urandom;
    aluc  = 4'($urandom_range(0, 15));
    repeat (3) begin
      @(negedge clk);
      a    = $urandom;
      b    = $urandom;
      aluc = 4'($urandom_range(0, 15));
    end
    #1;
    cmp("reset", '0);
    @(negedge clk);
    rst_n = 1'b1;

    vec("addu_5_3",  32'd5, 32'd3, 4'b0000, 32'd8, 4'b0000);
    vec("slt_min",   32'h8000_0000, 32'd1, 4'b1011, 32'd1, 4'b0000);
    vec("sltu_min",  32'h8000_0000, 32'd1, 4'b1010, 32'd0, 4'b1000);
    vec("add_ovf",   32'h7FFF_FFFF, 32'd1, 4'b0010,
        32'h8000_0000, 4'b0011);
    vec("addu_wrap", 32'hFFFF_FFFF, 32'd1, 4'b0000, 32'd0, 4'b1100);
    vec("addu_noov", 32'h7FFF_FFFF, 32'd1, 4'b0000,
        32'h8000_0000, 4'b0010);
    vec("subu_brw",  32'd3, 32'd5, 4'b0001, 32'hFFFF_FFFE, 4'b0110);
    vec("sub_ovf",   32'h8000_0000, 32'd1, 4'b0011,
        32'h7FFF_FFFF, 4'b0001);
    vec("srl_sh0",   32'h8000_0000, 32'hFFFF_FFFF, 4'b1101,
        32'hFFFF_FFFF, 4'b0010);
    vec("sra_4",     32'd4, 32'h8000_0000, 4'b1100,
        32'hF800_0000, 4'b0010);
    vec("sra_31",    32'hFFFF_FFFF, 32'h8000_0000, 4'b1100,
        32'hFFFF_FFFF, 4'b0010);
    vec("sll_1",     32'd1, 32'h8000_0001, 4'b1110, 32'd2, 4'b0100);
    vec("sll_alias", 32'd1, 32'h8000_0001, 4'b1111, 32'd2, 4'b0100);
    vec("and",       32'hF0F0_F0F0, 32'hFF00_FF00, 4'b0100,
        32'hF000_F000, 4'b0010);
    vec("nor",       32'hF0F0_F0F0, 32'hFF00_FF00, 4'b0111,
        32'h000F_000F, 4'b0000);
    vec("lui",       32'd0, 32'h0000_1234, 4'b1000,
        32'h1234_0000, 4'b0000);
    vec("lui_alias", 32'd0, 32'hABCD_1234, 4'b1001,
        32'h1234_0000, 4'b0000);

    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      a    = 32'($urandom_range(0, 31));
      b    = 32'($urandom_range(0, 31));
      aluc = (i % 2 == 0) ? 4'b1011 : 4'b1010;
    end

    // Opcode changes every cycle; per-edge model covers latency.
    for (int i = 0; i < 48; i++) begin
      @(negedge clk);
      a    = $urandom;
      b    = $urandom;
      aluc = 4'(i % 16);
    end

    vec("pre_rst", 32'd7, 32'd9, 4'b0101, 32'd15, 4'b0000);
    @(negedge clk);
    a    = 32'hFFFF_FFFF;
    b    = 32'd1;
    aluc = 4'b0000;
    #2;
    rst_n = 1'b0;
    #1;
    cmp("async_rst", '0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    a     = 32'd10;
    b     = 32'd4;
    aluc  = 4'b0011;
    @(posedge clk);
    #2;
    cmp("post_rst", '{r: 32'd6, z: 1'b0, c: 1'b0, n: 1'b0, v: 1'b0});

    repeat (2) @(negedge clk);
    done = 1'b1;
    $display("End of test - %0d assertions evaluated, %0d failures",
             nchk, nfail);
    $finish;
  end

endmodule
